// File: rtl/onehot_codec.sv
// onehot_codec
// Registered, handshaked binary <-> one-hot codec with a 2-entry output
// buffer. Each accepted transaction carries its own direction (mode), and
// illegal inputs are reported on out_err_o rather than being passed through.
//
// Optional build macro: ONEHOT_CODEC_ERRCNT_EN
//   defined   : err_cnt_o is a saturating count of accepted illegal inputs
//   undefined : err_cnt_o is tied to zero and no counter flops exist
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid_i   input transaction valid
//   in_ready_o   block can accept an input this cycle (registered)
//   mode_i       0 = binary->one-hot, 1 = one-hot->binary
//   in_data_i    mode 0: index in [BIN_W-1:0]; mode 1: one-hot vector
//   out_valid_o  output transaction valid
//   out_ready_i  consumer accepts the output
//   out_data_o   mode 0: one-hot vector; mode 1: zero-extended index
//   out_mode_o   mode of the presented transaction
//   out_err_o    presented transaction had an illegal input
//   err_cnt_o    saturating error count (optional feature)

module onehot_codec #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 mode_i,
    input  logic [ONE_HOT_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ONE_HOT_W-1:0] out_data_o,
    output logic                 out_mode_o,
    output logic                 out_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [1:0]           count;
    logic [1:0]           count_next;
    logic                 in_ready_q;
    logic                 push;
    logic                 pop;

    logic                 head_mode;
    logic                 head_err;
    logic [ONE_HOT_W-1:0] head_data;
    logic                 tail_mode;
    logic                 tail_err;
    logic [ONE_HOT_W-1:0] tail_data;

    logic [ONE_HOT_W-1:0] enc_data;
    logic                 enc_err;
    logic [BIN_W-1:0]     lowest;
    logic                 multi;

    assign push = in_valid_i & in_ready_q;
    assign pop  = (count != 2'd0) & out_ready_i;

    // Translate the incoming word for its mode. The one-hot decode scans from
    // the top down so the last assignment wins, leaving the lowest set bit.
    always_comb begin
        enc_data = '0;
        enc_err  = 1'b0;
        lowest   = '0;
        multi    = 1'b0;
        if (!mode_i) begin
            if ({1'b0, in_data_i[BIN_W-1:0]} < (BIN_W+1)'(ONE_HOT_W)) begin
                enc_data = ONE_HOT_W'(1) << in_data_i[BIN_W-1:0];
            end else begin
                enc_err = 1'b1;
            end
        end else begin
            for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
                if (in_data_i[i]) begin
                    lowest = BIN_W'(i);
                end
            end
            multi    = (in_data_i & (in_data_i - ONE_HOT_W'(1))) != '0;
            enc_data = ONE_HOT_W'(lowest);
            enc_err  = (in_data_i == '0) | multi;
        end
    end

    // Occupancy bookkeeping: push and pop together leave the count unchanged.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Two-slot FIFO where the head slot drives the outputs directly. A new
    // entry goes straight to the head when the head is empty or leaving this
    // cycle; otherwise it waits in the tail. in_ready is registered from the
    // next count so it never depends combinationally on out_ready_i.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= 2'd0;
            in_ready_q <= 1'b0;
            head_mode  <= 1'b0;
            head_err   <= 1'b0;
            head_data  <= '0;
            tail_mode  <= 1'b0;
            tail_err   <= 1'b0;
            tail_data  <= '0;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next < 2'd2);
            if (pop && (count == 2'd2)) begin
                head_mode <= tail_mode;
                head_err  <= tail_err;
                head_data <= tail_data;
            end
            if (push) begin
                if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                    head_mode <= mode_i;
                    head_err  <= enc_err;
                    head_data <= enc_data;
                end else begin
                    tail_mode <= mode_i;
                    tail_err  <= enc_err;
                    tail_data <= enc_data;
                end
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (count != 2'd0);
    assign out_data_o  = head_data;
    assign out_mode_o  = head_mode;
    assign out_err_o   = head_err;

`ifdef ONEHOT_CODEC_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Errors are counted when the input is accepted, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (push && enc_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_onehot_codec.sv
// tb_onehot_codec
// Scoreboard bench for onehot_codec. Stimulus pushes expected results into a
// queue per instance; monitors pop and compare whenever an output retires.
// A default instance (16-wide) and a 12-wide instance with a 2-bit error
// counter are exercised.

module tb_onehot_codec;

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_mode;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        in_valid12;
    logic        in_ready12;
    logic        mode12;
    logic [11:0] in_data12;
    logic        out_valid12;
    logic        out_ready12;
    logic [11:0] out_data12;
    logic        out_mode12;
    logic        out_err12;
    logic [1:0]  err_cnt12;

    exp_t        sb[$];
    exp_t        sb12[$];
    exp_t        mon_e;
    exp_t        mon_e12;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    onehot_codec #(.BIN_W(4), .ONE_HOT_W(16), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .mode_i(mode), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_mode_o(out_mode), .out_err_o(out_err), .err_cnt_o(err_cnt)
    );

    onehot_codec #(.BIN_W(4), .ONE_HOT_W(12), .ERR_CNT_W(2)) dut12 (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid12), .in_ready_o(in_ready12), .mode_i(mode12), .in_data_i(in_data12),
        .out_valid_o(out_valid12), .out_ready_i(out_ready12), .out_data_o(out_data12),
        .out_mode_o(out_mode12), .out_err_o(out_err12), .err_cnt_o(err_cnt12)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something upstream of every bounded wait goes wrong.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor for the 16-wide instance: every retiring output must match the
    // oldest expected entry, and timed entries must appear in their accept cycle.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out actual=%0h expected=none", {out_mode, out_err, out_data});
            end else begin
                mon_e = sb.pop_front();
                checkOutput("out16", {13'd0, out_mode, out_err, out_data}, {13'd0, mon_e.mode, mon_e.err, mon_e.data});
                if (mon_e.cyc >= 0) checkOutput("latency16", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Monitor for the 12-wide instance.
    always @(negedge clk) begin
        if (!reset && out_valid12 && out_ready12) begin
            if (sb12.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out12 actual=%0h expected=none", {out_mode12, out_err12, out_data12});
            end else begin
                mon_e12 = sb12.pop_front();
                checkOutput("out12", {13'd0, out_mode12, out_err12, 4'd0, out_data12},
                            {13'd0, mon_e12.mode, mon_e12.err, mon_e12.data});
                if (mon_e12.cyc >= 0) checkOutput("latency12", 32'(cyc), 32'(mon_e12.cyc));
            end
        end
    end

    task automatic idle();
        in_valid   = 1'b0;
        mode       = 1'bx;
        in_data    = 'x;
        in_valid12 = 1'b0;
        mode12     = 1'bx;
        in_data12  = 'x;
    endtask

    // Drive one transaction (called just after a rising edge), wait for it to
    // be accepted, then queue its expected result.
    task automatic applyStimulus(input bit sel, input logic m, input logic [15:0] d,
                                 input logic [15:0] ed, input logic ee, input bit timed);
        bit   rdy;
        int   waited = 0;
        exp_t e;
        if (!sel) begin
            in_valid = 1'b1;
            mode     = m;
            in_data  = d;
        end else begin
            in_valid12 = 1'b1;
            mode12     = m;
            in_data12  = d[11:0];
        end
        forever begin
            rdy = sel ? in_ready12 : in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 40) break;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=%0d expected=accept", waited);
        end else begin
            if (timed) checkOutput("no_stall", 32'(waited), 32'd0);
            e.mode = m;
            e.data = ed;
            e.err  = ee;
            e.cyc  = timed ? cyc : -1;
            if (!sel) sb.push_back(e);
            else      sb12.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || sb12.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", 32'(sb.size() + sb12.size()), 32'd0);
    endtask

    initial begin : stim
        logic [1:0] exp_cnt[5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;

        idle();
        out_ready   = 1'b1;
        out_ready12 = 1'b1;

        // Reset state while reset is held.
        #12;
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data",  {16'd0, out_data}, 32'd0);
        checkOutput("rst_mode_err", {30'd0, out_mode, out_err}, 32'd0);
        checkOutput("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", {31'd0, in_ready}, 32'd1);
        checkOutput("valid_after_rst", {31'd0, out_valid}, 32'd0);

        // Mode 0 sweep, back-to-back with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b0, 16'(i), 16'(1) << i, 1'b0, 1);
        end
        // Upper bits ignored in mode 0.
        applyStimulus(0, 1'b0, 16'hFFF3, 16'h0008, 1'b0, 1);

        // Mode 1 decode, legal and illegal.
        applyStimulus(0, 1'b1, 16'h0400, 16'd10, 1'b0, 1);
        applyStimulus(0, 1'b1, 16'h0000, 16'd0,  1'b1, 1);
        applyStimulus(0, 1'b1, 16'h0022, 16'd1,  1'b1, 1);
        applyStimulus(0, 1'b1, 16'h8000, 16'd15, 1'b0, 1);
        applyStimulus(0, 1'b1, 16'hFFFF, 16'd0,  1'b1, 1);
        idle();
        waitDrain();

        // Backpressure: two entries fill the buffer, the third waits.
        out_ready = 1'b0;
        applyStimulus(0, 1'b1, 16'h0400, 16'd10,   1'b0, 0);
        applyStimulus(0, 1'b0, 16'h0003, 16'h0008, 1'b0, 0);
        checkOutput("ready_full", {31'd0, in_ready}, 32'd0);
        fork
            applyStimulus(0, 1'b1, 16'h0022, 16'd1, 1'b1, 0);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
                    checkOutput("hold_out", {14'd0, out_mode, out_err, out_data}, {14'd0, 1'b1, 1'b0, 16'd10});
                    checkOutput("hold_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle();
        waitDrain();

        // Reset between edges with two entries buffered.
        out_ready = 1'b0;
        applyStimulus(0, 1'b1, 16'h8000, 16'd15,   1'b0, 0);
        applyStimulus(0, 1'b0, 16'h0000, 16'h0001, 1'b0, 0);
        idle();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_out", {14'd0, out_mode, out_err, out_data}, 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_errcnt", {24'd0, err_cnt}, 32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midrst_no_stale", {31'd0, out_valid}, 32'd0);

        // 12-wide instance: out-of-range index and the saturating error count.
        applyStimulus(1, 1'b0, 16'h000C, 16'd0, 1'b1, 1);
`ifdef ONEHOT_CODEC_ERRCNT_EN
        checkOutput("errcnt_0", {30'd0, err_cnt12}, {30'd0, exp_cnt[0]});
`else
        checkOutput("errcnt_0", {30'd0, err_cnt12}, 32'd0);
`endif
        applyStimulus(1, 1'b0, 16'h000D, 16'd0, 1'b1, 1);
`ifdef ONEHOT_CODEC_ERRCNT_EN
        checkOutput("errcnt_1", {30'd0, err_cnt12}, {30'd0, exp_cnt[1]});
`else
        checkOutput("errcnt_1", {30'd0, err_cnt12}, 32'd0);
`endif
        applyStimulus(1, 1'b0, 16'h000F, 16'd0, 1'b1, 1);
`ifdef ONEHOT_CODEC_ERRCNT_EN
        checkOutput("errcnt_2", {30'd0, err_cnt12}, {30'd0, exp_cnt[2]});
`else
        checkOutput("errcnt_2", {30'd0, err_cnt12}, 32'd0);
`endif
        applyStimulus(1, 1'b1, 16'h0000, 16'd0, 1'b1, 1);
`ifdef ONEHOT_CODEC_ERRCNT_EN
        checkOutput("errcnt_3", {30'd0, err_cnt12}, {30'd0, exp_cnt[3]});
`else
        checkOutput("errcnt_3", {30'd0, err_cnt12}, 32'd0);
`endif
        applyStimulus(1, 1'b1, 16'h0005, 16'd0, 1'b1, 1);
`ifdef ONEHOT_CODEC_ERRCNT_EN
        checkOutput("errcnt_4", {30'd0, err_cnt12}, {30'd0, exp_cnt[4]});
`else
        checkOutput("errcnt_4", {30'd0, err_cnt12}, 32'd0);
`endif
        applyStimulus(1, 1'b0, 16'h000B, 16'h0800, 1'b0, 1);
        applyStimulus(1, 1'b1, 16'h0800, 16'd11,   1'b0, 1);
        idle();
        waitDrain();
        checkOutput("errcnt16_clear", {24'd0, err_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
